mem_arbiter: RTL

Single-port memory arbiter and pipeline sequencer for the 5-stage MIPS core. Time-multiplexes one unified instruction/data memory port between the IF stage fetch and the MEM stage load/store. While accesses are outstanding it holds a global `stall` that freezes every pipeline register. It also enforces a bounded wait per access and flags a sticky error on timeout.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter_wait_timer.sv | 30 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    REL   = 2'd3
  } state_t;

  // Read data substituted when an access gives up waiting for the memory
  localparam logic [31:0] TIMEOUT_DATA = 32'h0;

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// Per-access wait counter: counts cycles without mem_ready, saturating at MAX_WAIT.
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] r_count;

  // Count wait cycles; clear restarts the count for the next access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (en && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Time-multiplexes one unified memory port between the IF fetch and the MEM
// load/store, holding the pipeline stalled until both accesses are done.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  state_t      r_state;
  state_t      w_next;
  logic        r_if_req;
  logic [31:0] r_if_addr;
  logic        r_dm_we;
  logic [31:0] r_dm_addr;
  logic [31:0] r_dm_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        r_err;

  logic        w_access;
  logic        w_expired;
  logic        w_timeout;
  logic        w_done;
  logic        w_clear;

  assign w_access  = (r_state == DATA) || (r_state == FETCH);
  assign w_timeout = w_access && w_expired && !mem_ready;
  assign w_done    = w_access && (mem_ready || w_expired);
  // Restart the count outside accesses and whenever one completes, so each
  // access state is entered with a zero count
  assign w_clear   = !w_access || w_done;

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .en      (!mem_ready),
    .expired (w_expired)
  );

  // State register; async reset returns to ARB so mem_req drops at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ARB;
    else        r_state <= w_next;
  end

  // Next-state decode: data access first (older instruction), then fetch
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB: begin
        if (dm_req)      w_next = DATA;
        else if (if_req) w_next = FETCH;
        else             w_next = REL;
      end
      DATA:    if (w_done) w_next = r_if_req ? FETCH : REL;
      FETCH:   if (w_done) w_next = REL;
      REL:     w_next = ARB;
      default: w_next = ARB;
    endcase
  end

  // Memory port and stall decoded from state and holding registers
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    stall     = (r_state != REL);
    case (r_state)
      DATA: begin
        mem_req   = 1'b1;
        mem_we    = r_dm_we;
        mem_addr  = r_dm_addr;
        mem_wdata = r_dm_wdata;
      end
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = r_if_addr;
      end
      default: ;
    endcase
  end

  // Request holding registers, sampled only while arbitrating
  always_ff @(posedge clk) begin
    if (r_state == ARB) begin
      r_if_req   <= if_req;
      r_if_addr  <= if_addr;
      r_dm_we    <= dm_we;
      r_dm_addr  <= dm_addr;
      r_dm_wdata <= dm_wdata;
    end
  end

  // Read-data capture and sticky timeout flag; stores leave dm_rdata alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_rdata <= 32'h0;
      r_dm_rdata <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      if ((r_state == DATA) && w_done && !r_dm_we)
        r_dm_rdata <= mem_ready ? mem_rdata : TIMEOUT_DATA;
      if ((r_state == FETCH) && w_done)
        r_if_rdata <= mem_ready ? mem_rdata : TIMEOUT_DATA;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;
  assign err      = r_err;

endmodule
